// File: rtl/ps2_key_frontend_pkg.sv
// Shared constants for the PS/2 keyboard front end: seven-segment glyphs,
// scan codes used by downstream key handling, and the scan-code-to-ASCII table.
package ps2_key_frontend_pkg;

   // Segment order {g,f,e,d,c,b,a}, active-low.
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   // Scan-code set 2, lower case; anything unlisted reads as 0x00.
   function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
      logic [7:0] a;
      a = 8'h00;
      case (code)
         8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
         8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
         8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
         8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
         8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
         8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
         8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
         8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
         8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
         8'h3E: a = 8'h38;  8'h46: a = 8'h39;
         8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;  8'h0D: a = 8'h09;
         8'h4E: a = 8'h2D;  8'h55: a = 8'h3D;  8'h54: a = 8'h5B;  8'h5B: a = 8'h5D;
         8'h5D: a = 8'h5C;  8'h4C: a = 8'h3B;  8'h52: a = 8'h27;  8'h41: a = 8'h2C;
         8'h49: a = 8'h2E;  8'h4A: a = 8'h2F;  8'h0E: a = 8'h60;
         SC_BREAK, SC_EXT, SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_CAPS: a = 8'h00;
         default: a = 8'h00;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/ps2_key_frontend_seg7.sv
// Hex nibble to seven-segment decoder with blanking; purely combinational.
module seg7_hex_decoder
   import ps2_key_frontend_pkg::*;
(
   input  logic [4:0] i_code,   // {blank, nibble}
   output logic [6:0] o_seg
);

   // Blank overrides the nibble glyph.
   always_comb begin
      o_seg = SEG_BLANK;
      if (!i_code[4]) begin
         case (i_code[3:0])
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            default: o_seg = SEG_F;
         endcase
      end
   end

endmodule

// File: rtl/ps2_key_frontend.sv
// PS/2 keyboard front end: frame receiver, scan-code FIFO, ASCII lookup and
// four hex digits showing the FIFO head code and its ASCII value.
module ps2_key_frontend
   import ps2_key_frontend_pkg::*;
#(
   parameter int FIFO_DEPTH_LOG2 = 3,
   parameter int SYNC_STAGES     = 3
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   input  logic       upper,
   input  logic       blank,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow,
   output logic [7:0] ascii,
   output logic [6:0] hex0,
   output logic [6:0] hex1,
   output logic [6:0] hex2,
   output logic [6:0] hex3
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE = 1;

   logic [SYNC_STAGES-1:0]     r_sync;
   logic [3:0]                 r_count;
   logic [9:0]                 r_frame;   // bit0 = start ... bit9 = parity
   logic [7:0]                 r_fifo [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] r_w_ptr;
   logic [FIFO_DEPTH_LOG2-1:0] r_r_ptr;
   logic                       r_overflow;
   logic [7:0]                 r_ascii;

   logic                       w_fall;
   logic                       w_frame_done;
   logic                       w_frame_ok;
   logic [FIFO_DEPTH_LOG2-1:0] w_w_ptr_nxt;
   logic                       w_full;
   logic                       w_push;
   logic                       w_pop;
   logic [7:0]                 w_rom;
   logic [7:0]                 w_ascii_nxt;

   // Synchronize the device clock; idle-high reset avoids a false edge.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) r_sync <= '1;
      else       r_sync <= {r_sync[SYNC_STAGES-2:0], ps2_clk};
   end

   assign w_fall = r_sync[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES-2];

   // Bit counter and shift register; bits 0..9 shift in, stop bit is judged live.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_count <= 4'd0;
         r_frame <= '0;
      end else if (w_fall) begin
         if (r_count == 4'd10) begin
            r_count <= 4'd0;
         end else begin
            r_count <= r_count + 4'd1;
            r_frame <= {ps2_data, r_frame[9:1]};
         end
      end
   end

   assign w_frame_done = w_fall && (r_count == 4'd10);
   assign w_frame_ok   = ~r_frame[0] & ps2_data & (^r_frame[9:1]);
   assign w_w_ptr_nxt  = r_w_ptr + PTR_ONE;
   assign w_full       = (w_w_ptr_nxt == r_r_ptr);
   assign ready        = (r_w_ptr != r_r_ptr);
   assign w_push       = w_frame_done & w_frame_ok & ~w_full;
   assign w_pop        = ready & ~nextdata_n;
   assign data         = r_fifo[r_r_ptr];
   assign overflow     = r_overflow;

   // FIFO storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_w_ptr] <= r_frame[8:1];
   end

   // Pointers and sticky overflow; a drop in the same cycle as a pop still flags.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_w_ptr    <= '0;
         r_r_ptr    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_w_ptr <= w_w_ptr_nxt;
         if (w_pop)  r_r_ptr <= r_r_ptr + PTR_ONE;
         if (w_frame_done && w_frame_ok && w_full) r_overflow <= 1'b1;
         else if (w_pop)                           r_overflow <= 1'b0;
      end
   end

   assign w_rom       = scan_to_ascii(data);
   assign w_ascii_nxt = (upper && (w_rom >= 8'h61) && (w_rom <= 8'h7A)) ? (w_rom - 8'h20) : w_rom;

   // Registered ASCII of the FIFO head.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) r_ascii <= 8'h00;
      else       r_ascii <= w_ascii_nxt;
   end

   assign ascii = r_ascii;

   seg7_hex_decoder u_hex0 (.i_code({blank, data[3:0]}),  .o_seg(hex0));
   seg7_hex_decoder u_hex1 (.i_code({blank, data[7:4]}),  .o_seg(hex1));
   seg7_hex_decoder u_hex2 (.i_code({blank, ascii[3:0]}), .o_seg(hex2));
   seg7_hex_decoder u_hex3 (.i_code({blank, ascii[7:4]}), .o_seg(hex3));

endmodule

// File: tb/tb_ps2_key_frontend.sv
// Self-checking bench for ps2_key_frontend: directed scenarios plus a
// randomized push/pop mix checked against a queue-based reference model.
module tb_ps2_key_frontend;

   localparam int HALF = 15;   // PS/2 half period in system clocks

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       nextdata_n = 1'b1;
   logic       upper = 1'b0;
   logic       blank = 1'b0;
   logic [7:0] data;
   logic       ready;
   logic       overflow;
   logic [7:0] ascii;
   logic [6:0] hex0, hex1, hex2, hex3;

   int errors = 0;
   int checks = 0;

   logic [7:0] q[$];
   logic       m_ovf;

   logic [7:0] let_codes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                  8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                  8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
   logic [7:0] dig_codes [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
   logic [6:0] seg_tab [16] = '{7'b1000000,7'b1111001,7'b0100100,7'b0110000,
                                7'b0011001,7'b0010010,7'b0000010,7'b1111000,
                                7'b0000000,7'b0010000,7'b0001000,7'b0000011,
                                7'b1000110,7'b0100001,7'b0000110,7'b0001110};

   always #5 clk = ~clk;

   ps2_key_frontend dut (
      .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .nextdata_n(nextdata_n), .upper(upper), .blank(blank),
      .data(data), .ready(ready), .overflow(overflow), .ascii(ascii),
      .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
   );

   function automatic logic [7:0] model_ascii(input logic [7:0] code, input logic up);
      for (int i = 0; i < 26; i++)
         if (code == let_codes[i]) return (up ? 8'd65 : 8'd97) + 8'(i);
      for (int i = 0; i < 10; i++)
         if (code == dig_codes[i]) return 8'd48 + 8'(i);
      if (code == 8'h29) return 8'h20;
      if (code == 8'h5A) return 8'h0D;
      if (code == 8'h66) return 8'h08;
      return 8'h00;
   endfunction

   function automatic logic [7:0] pick_code();
      int r;
      r = $urandom_range(0, 40);
      if (r < 26) return let_codes[r];
      if (r < 36) return dig_codes[r-26];
      case (r)
         36: return 8'h29;
         37: return 8'h5A;
         38: return 8'h66;
         39: return 8'hF0;
         default: return 8'h12;
      endcase
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop);
      logic [10:0] bits;
      bits = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
      send_bits(bits, 11);
      repeat (5) @(negedge clk);
   endtask

   task automatic pop_one();
      @(negedge clk) nextdata_n = 1'b0;
      @(negedge clk) nextdata_n = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk) clrn = 1'b0;
      repeat (3) @(negedge clk);
      clrn = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk) clrn = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      checks++; if (ascii !== 8'h00) begin errors++; $display("FAIL reset_ascii: got %h expected 00", ascii); end
      checks++; if (hex2 !== 7'b1000000 || hex3 !== 7'b1000000) begin
         errors++; $display("FAIL reset_hex23: got %b %b expected 1000000 1000000", hex3, hex2); end
      clrn = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_basic_frame();
      send_frame(8'h1C, 1'b0, 1'b0);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b expected 1", ready); end
      checks++; if (data !== 8'h1C) begin errors++; $display("FAIL basic_data: got %h expected 1c", data); end
      checks++; if (hex0 !== 7'b1000110 || hex1 !== 7'b1111001) begin
         errors++; $display("FAIL basic_hex01: got %b %b expected 1111001 1000110", hex1, hex0); end
      checks++; if (ascii !== 8'h61) begin errors++; $display("FAIL basic_ascii: got %h expected 61", ascii); end
      checks++; if (hex3 !== 7'b0000010 || hex2 !== 7'b1111001) begin
         errors++; $display("FAIL basic_hex23: got %b %b expected 0000010 1111001", hex3, hex2); end
   endtask

   task automatic test_upper();
      @(negedge clk) upper = 1'b1;
      @(negedge clk);
      checks++; if (ascii !== 8'h41) begin errors++; $display("FAIL upper_a: got %h expected 41", ascii); end
      pop_one();
      send_frame(8'h45, 1'b0, 1'b0);
      checks++; if (data !== 8'h45 || ascii !== 8'h30) begin
         errors++; $display("FAIL upper_digit: got data %h ascii %h expected 45 30", data, ascii); end
      pop_one();
      upper = 1'b0;
      @(negedge clk);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL upper_drain: got ready %b expected 0", ready); end
   endtask

   task automatic test_bad_frames();
      send_frame(8'h1C, 1'b1, 1'b0);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL bad_parity: got ready %b expected 0", ready); end
      send_frame(8'h1C, 1'b0, 1'b1);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL bad_stop: got ready %b expected 0", ready); end
      send_frame(8'h1C, 1'b0, 1'b0);
      checks++; if (ready !== 1'b1 || data !== 8'h1C) begin
         errors++; $display("FAIL bad_recover: got ready %b data %h expected 1 1c", ready, data); end
      pop_one();
   endtask

   task automatic test_overflow();
      logic [7:0] codes [8];
      codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};
      for (int i = 0; i < 8; i++) send_frame(codes[i], 1'b0, 1'b0);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
      checks++; if (data !== 8'h16) begin errors++; $display("FAIL ovf_head: got %h expected 16", data); end
      pop_one();
      checks++; if (data !== 8'h1E || overflow !== 1'b0) begin
         errors++; $display("FAIL ovf_pop: got data %h ovf %b expected 1e 0", data, overflow); end
      checks++; if (ascii !== 8'h31) begin errors++; $display("FAIL ascii_latency_old: got %h expected 31", ascii); end
      @(negedge clk);
      checks++; if (ascii !== 8'h32) begin errors++; $display("FAIL ascii_latency_new: got %h expected 32", ascii); end
      for (int i = 2; i < 7; i++) begin
         pop_one();
         checks++; if (data !== codes[i] || ready !== 1'b1) begin
            errors++; $display("FAIL ovf_drain%0d: got data %h ready %b expected %h 1", i, data, ready, codes[i]); end
      end
      pop_one();
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ovf_empty: got ready %b expected 0", ready); end
      pop_one();
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL pop_empty: got ready %b expected 0", ready); end
   endtask

   task automatic test_blank_and_break();
      send_frame(8'hF0, 1'b0, 1'b0);
      checks++; if (data !== 8'hF0 || ascii !== 8'h00) begin
         errors++; $display("FAIL break_code: got data %h ascii %h expected f0 00", data, ascii); end
      @(negedge clk) blank = 1'b1;
      @(negedge clk);
      checks++; if ({hex3, hex2, hex1, hex0} !== {4{7'b1111111}}) begin
         errors++; $display("FAIL blank: got %b %b %b %b expected all 1111111", hex3, hex2, hex1, hex0); end
      blank = 1'b0;
      @(negedge clk);
      checks++; if (hex1 !== 7'b0001110 || hex0 !== 7'b1000000) begin
         errors++; $display("FAIL unblank: got %b %b expected 0001110 1000000", hex1, hex0); end
      pop_one();
   endtask

   task automatic test_reset_midframe();
      logic [10:0] bits;
      bits = {1'b1, 1'b1, 8'h5A, 1'b0};
      send_bits(bits, 5);
      do_reset();
      send_frame(8'h29, 1'b0, 1'b0);
      checks++; if (ready !== 1'b1 || data !== 8'h29) begin
         errors++; $display("FAIL midreset_data: got ready %b data %h expected 1 29", ready, data); end
      checks++; if (ascii !== 8'h20) begin errors++; $display("FAIL midreset_ascii: got %h expected 20", ascii); end
      pop_one();
   endtask

   task automatic test_random();
      int op;
      logic [7:0] code;
      logic [7:0] exp_a;
      do_reset();
      q.delete();
      m_ovf = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk) upper = 1'($urandom_range(0, 1));
         op = $urandom_range(0, 5);
         if (op <= 2) begin
            code = pick_code();
            send_frame(code, 1'b0, 1'b0);
            if (q.size() == 7) m_ovf = 1'b1;
            else q.push_back(code);
         end else if (op == 3) begin
            code = pick_code();
            if ($urandom_range(0, 1) == 1) send_frame(code, 1'b1, 1'b0);
            else                           send_frame(code, 1'b0, 1'b1);
         end else begin
            pop_one();
            @(negedge clk);
            if (q.size() > 0) begin
               void'(q.pop_front());
               m_ovf = 1'b0;
            end
         end
         checks++; if (ready !== (q.size() != 0)) begin
            errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", n, ready, q.size() != 0); end
         checks++; if (overflow !== m_ovf) begin
            errors++; $display("FAIL rand_ovf[%0d]: got %b expected %b", n, overflow, m_ovf); end
         if (q.size() != 0) begin
            exp_a = model_ascii(q[0], upper);
            checks++; if (data !== q[0]) begin
               errors++; $display("FAIL rand_data[%0d]: got %h expected %h", n, data, q[0]); end
            checks++; if (ascii !== exp_a) begin
               errors++; $display("FAIL rand_ascii[%0d]: got %h expected %h", n, ascii, exp_a); end
            checks++; if (hex0 !== seg_tab[q[0][3:0]] || hex3 !== seg_tab[exp_a[7:4]]) begin
               errors++; $display("FAIL rand_hex[%0d]: got %b %b expected %b %b", n, hex3, hex0,
                                  seg_tab[exp_a[7:4]], seg_tab[q[0][3:0]]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_upper();
      test_bad_frames();
      test_overflow();
      test_blank_and_break();
      test_reset_midframe();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
